// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared RV32I decode types, opcode/funct constants and ALU-op helper
package decode_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_B,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    alu_op_t    alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       jalr;
    logic       auipc;
    logic       illegal;
  } ctrl_t;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_from_f3 = ALU_ADD;
    case (f3)
      F3_ADD:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_from_f3 = ALU_SLL;
      F3_SLT:  alu_from_f3 = ALU_SLT;
      F3_SLTU: alu_from_f3 = ALU_SLTU;
      F3_XOR:  alu_from_f3 = ALU_XOR;
      F3_SRL:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_from_f3 = ALU_OR;
      F3_AND:  alu_from_f3 = ALU_AND;
      default: alu_from_f3 = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_rv_decoder.sv
// rv_decoder: combinational RV32I(E) instruction decode into immediate, register fields and control
module rv_decoder
  import decode_stage_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output ctrl_t       ctrl_o
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic shift, uses_rd, uses_rs1, uses_rs2, bad;
  logic [31:0] imm;
  ctrl_t c;
  assign opc = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign shift = f3 == F3_SLL || f3 == F3_SRL;
  always_comb begin
    imm = '0;
    c = '0;
    uses_rd = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        uses_rd = 1'b1;
        imm = {instr_i[31:12], 12'b0};
        c.alu_src = 1'b1;
        c.alu_op = opc == OPC_LUI ? ALU_PASS_B : ALU_ADD;
        c.auipc = opc == OPC_AUIPC;
      end
      OPC_JAL: begin
        uses_rd = 1'b1;
        imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        c.alu_src = 1'b1;
        c.jump = 1'b1;
      end
      OPC_JALR: begin
        uses_rd = 1'b1;
        uses_rs1 = 1'b1;
        imm = {{20{instr_i[31]}}, instr_i[31:20]};
        c.alu_src = 1'b1;
        c.jump = 1'b1;
        c.jalr = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        c.alu_op = ALU_SUB;
        c.branch = 1'b1;
        c.branch_cond = f3;
        bad = f3[2:1] == 2'b01;  // funct3 010/011 are not branches
      end
      OPC_LOAD: begin
        uses_rd = 1'b1;
        uses_rs1 = 1'b1;
        imm = {{20{instr_i[31]}}, instr_i[31:20]};
        c.alu_src = 1'b1;
        c.mem_read = 1'b1;
        c.mem_size = f3[1:0];
        c.mem_unsigned = f3[2];
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        c.alu_src = 1'b1;
        c.mem_write = 1'b1;
        c.mem_size = f3[1:0];
      end
      OPC_OP_IMM: begin
        uses_rd = 1'b1;
        uses_rs1 = 1'b1;
        imm = shift ? {27'b0, instr_i[24:20]} : {{20{instr_i[31]}}, instr_i[31:20]};
        c.alu_src = 1'b1;
        c.alu_op = alu_from_f3(f3, shift && f7[5]);
        bad = shift && !(f7 == F7_ZERO || (f3 == F3_SRL && f7 == F7_ALT));
      end
      OPC_OP: begin
        uses_rd = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        c.alu_op = alu_from_f3(f3, f7[5]);
        bad = !(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL)));
      end
      default: bad = 1'b1;
    endcase
    if (RV32E) bad = bad || (uses_rd && instr_i[11]) || (uses_rs1 && instr_i[19]) || (uses_rs2 && instr_i[24]);
    c.illegal = bad;
    c.reg_write = uses_rd && instr_i[11:7] != 5'd0 && !bad;
    c.mem_read = c.mem_read && !bad;
    c.mem_write = c.mem_write && !bad;
  end
  assign imm_o = imm;
  assign ctrl_o = c;
  assign rd_o = uses_rd ? instr_i[11:7] : 5'd0;
  assign rs1_o = uses_rs1 ? instr_i[19:15] : 5'd0;
  assign rs2_o = uses_rs2 ? instr_i[24:20] : 5'd0;
  assign uses_rs1_o = uses_rs1;
  assign uses_rs2_o = uses_rs2;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with load-use bubble insertion and halt-on-illegal
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit RV32E = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output ctrl_t            out_ctrl,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  logic [31:0] dec_imm, pc_q, imm_q;
  logic [4:0] dec_rd, dec_rs1, dec_rs2, rd_q, rs1_q, rs2_q;
  logic dec_u1, dec_u2, valid_q, hazard, accept, bubble;
  ctrl_t dec_ctrl, ctrl_q;
  state_t state_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  rv_decoder #(.RV32E(RV32E)) u_dec (
    .instr_i(in_instr), .imm_o(dec_imm), .rd_o(dec_rd), .rs1_o(dec_rs1), .rs2_o(dec_rs2),
    .uses_rs1_o(dec_u1), .uses_rs2_o(dec_u2), .ctrl_o(dec_ctrl)
  );
  // load in the output register feeding a source of the offered instruction
  assign hazard = valid_q && ctrl_q.mem_read && rd_q != 5'd0 &&
                  ((dec_u1 && dec_rs1 == rd_q) || (dec_u2 && dec_rs2 == rd_q));
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush && state_q == RUN;
  assign accept = in_valid && in_ready;
  assign bubble = in_valid && hazard && out_ready && !flush && state_q == RUN;
  assign stall_d = bubble && !(&stall_q) ? stall_q + CNT_W'(1) : stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q <= '0;
      imm_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      ctrl_q <= '0;
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        valid_q <= 1'b0;
        state_q <= RUN;
      end else if (accept) begin
        valid_q <= 1'b1;
        pc_q <= in_pc;
        imm_q <= dec_imm;
        rd_q <= dec_rd;
        rs1_q <= dec_rs1;
        rs2_q <= dec_rs2;
        ctrl_q <= dec_ctrl;
        state_q <= dec_ctrl.illegal ? HALT : RUN;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
  assign out_valid = valid_q;
  assign out_pc = pc_q;
  assign out_imm = imm_q;
  assign out_rd = rd_q;
  assign out_rs1 = rs1_q;
  assign out_rs2 = rs2_q;
  assign out_ctrl = ctrl_q;
  assign halted = state_q == HALT;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector-table and hand-sequenced checks of decode_stage with an output scoreboard
module tb_decode_stage;
  import decode_stage_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, e_valid = 1'b0;
  logic in_ready, out_valid, halted, e_in_ready, e_out_valid, e_halted;
  logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm, e_pc, e_imm;
  logic [4:0] out_rd, out_rs1, out_rs2, e_rd, e_rs1, e_rs2;
  ctrl_t out_ctrl, e_ctrl;
  logic [15:0] stall_count, e_stall;
  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [4:0] rd, rs1, rs2;
    ctrl_t ctrl;
  } vec_t;
  vec_t sb[$];
  vec_t cur, tbl[12], lw_v, add_v, ill_v, a_v, b_v;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_ctrl(out_ctrl),
    .halted(halted), .stall_count(stall_count)
  );
  decode_stage #(.RV32E(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in_valid(e_valid), .in_ready(e_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_pc),
    .out_imm(e_imm), .out_rd(e_rd), .out_rs1(e_rs1), .out_rs2(e_rs2), .out_ctrl(e_ctrl),
    .halted(e_halted), .stall_count(e_stall)
  );

  function automatic ctrl_t mk(input logic rw, src, input alu_op_t op, input logic mr, mw,
                               input logic [1:0] sz, input logic un, br, input logic [2:0] bc,
                               input logic jp, jr, au, il);
    ctrl_t c;
    c.reg_write = rw; c.alu_src = src; c.alu_op = op; c.mem_read = mr; c.mem_write = mw;
    c.mem_size = sz; c.mem_unsigned = un; c.branch = br; c.branch_cond = bc; c.jump = jp;
    c.jalr = jr; c.auipc = au; c.illegal = il;
    return c;
  endfunction

  function automatic vec_t v(input logic [31:0] instr, pc, imm, input logic [4:0] rd, rs1, rs2,
                             input ctrl_t c);
    vec_t r;
    r.instr = instr; r.pc = pc; r.imm = imm; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.ctrl = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction from posedge+1 until it is accepted, bounded
  task automatic send(input vec_t e);
    bit ok;
    ok = 1'b0;
    cur = e;
    in_instr = e.instr;
    in_pc = e.pc;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=%h: got in_ready=0 expected 1 within 20 cycles", e.pc);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Scoreboard: push on accept, pop and compare on output transfer
  always @(negedge clk) begin : mon
    vec_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pc=%h expected no bundle", out_pc);
        end else begin
          e = sb.pop_front();
          if ({out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl} !==
              {e.pc, e.imm, e.rd, e.rs1, e.rs2, e.ctrl}) begin
            errors++;
            $display("FAIL bundle: got pc=%h imm=%h rd=%0d rs1=%0d rs2=%0d ctrl=%h expected pc=%h imm=%h rd=%0d rs1=%0d rs2=%0d ctrl=%h",
                     out_pc, out_imm, out_rd, out_rs1, out_rs2, out_ctrl,
                     e.pc, e.imm, e.rd, e.rs1, e.rs2, e.ctrl);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0]  = v(32'h00500093, 32'h1000, 32'h5,        1, 0, 0,  mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,0,0));
    tbl[1]  = v(32'h002101B3, 32'h1004, 32'h0,        3, 2, 2,  mk(1,0,ALU_ADD,0,0,0,0,0,0,0,0,0,0));
    tbl[2]  = v(32'h407302B3, 32'h1008, 32'h0,        5, 6, 7,  mk(1,0,ALU_SUB,0,0,0,0,0,0,0,0,0,0));
    tbl[3]  = v(32'h40325213, 32'h100C, 32'h3,        4, 4, 0,  mk(1,1,ALU_SRA,0,0,0,0,0,0,0,0,0,0));
    tbl[4]  = v(32'h12345337, 32'h1010, 32'h12345000, 6, 0, 0,  mk(1,1,ALU_PASS_B,0,0,0,0,0,0,0,0,0,0));
    tbl[5]  = v(32'h00512423, 32'h1014, 32'h8,        0, 2, 5,  mk(0,1,ALU_ADD,0,1,2,0,0,0,0,0,0,0));
    tbl[6]  = v(32'hFE209EE3, 32'h1018, 32'hFFFFFFFC, 0, 1, 2,  mk(0,0,ALU_SUB,0,0,0,0,1,1,0,0,0,0));
    tbl[7]  = v(32'h001000EF, 32'h101C, 32'h800,      1, 0, 0,  mk(1,1,ALU_ADD,0,0,0,0,0,0,1,0,0,0));
    tbl[8]  = v(32'h00C08067, 32'h1020, 32'hC,        0, 1, 0,  mk(0,1,ALU_ADD,0,0,0,0,0,0,1,1,0,0));
    tbl[9]  = v(32'h00001397, 32'h1024, 32'h1000,     7, 0, 0,  mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,1,0));
    tbl[10] = v(32'hFFF4C403, 32'h1028, 32'hFFFFFFFF, 8, 9, 0,  mk(1,1,ALU_ADD,1,0,0,1,0,0,0,0,0,0));
    tbl[11] = v(32'h00C5B533, 32'h102C, 32'h0,        10, 11, 12, mk(1,0,ALU_SLTU,0,0,0,0,0,0,0,0,0,0));
    lw_v  = v(32'h0000A103, 32'h2000, 32'h0, 2, 1, 0, mk(1,1,ALU_ADD,1,0,2,0,0,0,0,0,0,0));
    add_v = v(32'h002101B3, 32'h2004, 32'h0, 3, 2, 2, mk(1,0,ALU_ADD,0,0,0,0,0,0,0,0,0,0));
    ill_v = v(32'hFFFFFFFF, 32'h2100, 32'h0, 0, 0, 0, mk(0,0,ALU_ADD,0,0,0,0,0,0,0,0,0,1));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_pc_imm_rd", {out_pc ^ out_imm, 11'd0, out_rd, out_rs1, out_rs2}, 0);
    reset = 1'b0;
    step();

    // table: addi first with explicit latency check, then back-to-back
    send(tbl[0]);
    chk("addi_latency_valid", out_valid, 1);
    chk("addi_latency_imm", out_imm, 5);
    for (int i = 1; i < 12; i++) send(tbl[i]);
    repeat (3) step();

    // load-use: lw x2 then add x3,x2,x2
    cur = lw_v; in_instr = lw_v.instr; in_pc = lw_v.pc; in_valid = 1'b1;
    @(negedge clk); chk("lw_accept", in_ready, 1);
    step();
    cur = add_v; in_instr = add_v.instr; in_pc = add_v.pc;
    @(negedge clk); chk("hazard_in_ready", in_ready, 0); chk("hazard_lw_out", out_valid, 1);
    step();
    @(negedge clk); chk("bubble_valid", out_valid, 0); chk("bubble_then_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("add_after_bubble", {out_valid, 3'd0, out_rd}, {1'b1, 3'd0, 5'd3});
    chk("stall_count_1", stall_count, 1);
    step();

    // illegal -> HALT, flush -> RUN
    send(ill_v);
    cur = tbl[0]; in_instr = tbl[0].instr; in_pc = 32'h2104; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_in_ready", in_ready, 0);
      step();
    end
    flush = 1'b1;
    @(negedge clk); chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("flush_leaves_halt", halted, 0);
    send(v(32'h00500093, 32'h2108, 32'h5, 1, 0, 0, mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,0,0)));
    step();

    // backpressure then flush with an offered instruction
    a_v = v(32'h00500093, 32'h3000, 32'h5, 1, 0, 0, mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,0,0));
    b_v = v(32'h407302B3, 32'h3004, 32'h0, 5, 6, 7, mk(1,0,ALU_SUB,0,0,0,0,0,0,0,0,0,0));
    out_ready = 1'b0;
    send(a_v);
    cur = b_v; in_instr = b_v.instr; in_pc = b_v.pc; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, out_pc[30:0]} ^ out_imm, {1'b1, a_v.pc[30:0]} ^ a_v.imm);
      step();
    end
    out_ready = 1'b1;
    step();
    in_instr = 32'h00100093; in_pc = 32'h3008; flush = 1'b1;
    @(negedge clk); chk("flush_drops_offer", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("flush_clears_valid", out_valid, 0);
    step();

    // RV32E: x16 illegal on dut_e, legal on dut
    cur = v(32'h00100813, 32'h3100, 32'h1, 16, 0, 0, mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,0,0));
    in_instr = 32'h00100813; in_pc = 32'h3100; in_valid = 1'b1; e_valid = 1'b1;
    @(negedge clk); chk("e_accept", e_in_ready, 1);
    step();
    in_valid = 1'b0; e_valid = 1'b0;
    @(negedge clk); chk("e_x16_illegal", {e_out_valid, e_ctrl.illegal, e_halted}, 3'b111);
    step();

    // reset while holding a bundle
    out_ready = 1'b0;
    send(v(32'h00500093, 32'h4000, 32'h5, 1, 0, 0, mk(1,1,ALU_ADD,0,0,0,0,0,0,0,0,0,0)));
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_stall", stall_count, 1);
    #2 reset = 1'b1;
    #1 chk("reset_async_valid", out_valid, 0);
    chk("reset_async_stall", stall_count, 0);
    sb.delete();
    step();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk("post_reset_no_glitch", out_valid, 0);
    step();
    send(v(32'h00C5B533, 32'h4004, 32'h0, 10, 11, 12, mk(1,0,ALU_SLTU,0,0,0,0,0,0,0,0,0,0)));
    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter RV32E, default 0, meaning: 1 limits the register file to x0-x15, and any rd/rs1/rs2 field above 15 is illegal.
REQ-002 Parameter CNT_W, default 16, meaning: width of the saturating stall counter.
REQ-003 Ports (name, direction, width, meaning); the block uses one clock, and reset is asynchronous and active-high:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, instruction accepted this cycle when in_valid is also high.
- in_instr, in, 32, RV32I instruction word.
- in_pc, in, 32, PC of in_instr.
- flush, in, 1, kill all held and offered instructions; leave HALT.
- out_valid, out, 1, decoded bundle valid.
- out_ready, in, 1, downstream takes the bundle.
- out_pc, out, 32, registered PC.
- out_imm, out, 32, sign-extended immediate (I/S/B/U/J).
- out_rd, out, 5, destination register.
- out_rs1, out, 5, source register 1.
- out_rs2, out, 5, source register 2.
- out_ctrl, out, ctrl_t, control bundle (see REQ-020).
- halted, out, 1, state is HALT.
- stall_count, out, CNT_W, number of load-use bubbles inserted.

Function
REQ-004 The block SHALL be a single registered pipeline stage: an instruction accepted at edge N SHALL appear on out_* after edge N, with latency 1.
REQ-005 Handshake: accept = in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-006 in_ready SHALL be (!out_valid || out_ready) && !hazard && !flush && state==RUN.
REQ-007 While out_valid && !out_ready, every out_* SHALL hold stable.
REQ-008 hazard SHALL be out_valid && out_ctrl.mem_read && out_rd!=0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)), where rs1/rs2 are taken from in_instr.
REQ-009 When hazard is set and out_ready is high, out_valid SHALL drop to 0 for exactly one cycle (a bubble), and stall_count SHALL increment, saturating at all-ones.
REQ-010 uses_rs1 SHALL be 0 for LUI, AUIPC and JAL; uses_rs2 SHALL be 1 only for branch, store and reg-reg instructions.
REQ-011 flush SHALL clear out_valid at the next edge, SHALL drop any offered instruction, and SHALL override simultaneous accept and hazard.
REQ-012 The state machine SHALL have two states, RUN and HALT.
REQ-013 RUN->HALT SHALL occur when an accepted instruction decodes illegal; that bundle SHALL still be presented with out_ctrl.illegal=1.
REQ-014 HALT->RUN SHALL occur only on flush; in HALT, in_ready=0 and halted=1.
REQ-015 Illegal SHALL cover: an unknown opcode; an unknown funct3 or funct7 for reg-reg, shift or branch instructions; and, when RV32E=1, any used register field above 15.
REQ-016 The immediate SHALL be selected by format: I (loads, JALR, OP-IMM), S, B, U, J; shift immediates SHALL be shamt[4:0] zero-extended; R-type SHALL give 0.
REQ-017 The ALU op SHALL be an alu_op_t: ADD, SUB, XOR, OR, AND, PASS_B (LUI), SLL, SRL, SRA, SLT, SLTU. Loads, stores, AUIPC, JAL and JALR SHALL use ADD; branches SHALL use SUB.
REQ-018 mem_size SHALL be 0 for B, 1 for H, 2 for W; mem_unsigned SHALL be set for LBU/LHU.
REQ-019 branch_cond SHALL be funct3 for branches; jump SHALL be set for JAL/JALR and jalr SHALL be set for JALR only.
REQ-020 ctrl_t fields: reg_write, alu_src, alu_op, mem_read, mem_write, mem_size, mem_unsigned, branch, branch_cond, jump, jalr, auipc, illegal.
REQ-021 reg_write SHALL be 0 when rd==0, for stores and branches, and when illegal is set.
REQ-022 mem_read and mem_write SHALL be 0 when illegal is set.

Reset
REQ-023 On reset assertion, asynchronously: out_valid=0, state=RUN, halted=0, stall_count=0, and out_ctrl=all zeros.
REQ-024 out_pc, out_imm, out_rd, out_rs1 and out_rs2 SHALL reset to 0.
REQ-025 Reset mid-transfer SHALL discard the held instruction, with no output glitch after release.

Structure
REQ-026 A shared package SHALL hold alu_op_t, ctrl_t, the opcode constants and the funct3/funct7 constants.
REQ-027 One combinational sub-module, rv_decoder, SHALL map instruction to imm, rd, rs1, rs2, uses_rs1, uses_rs2 and ctrl.
REQ-028 decode_stage SHALL hold only the pipeline register, the hazard logic, the state machine and the counter.

Verification
REQ-029 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, imm=5, rd=1, alu_op=ADD, alu_src=1, reg_write=1.
REQ-030 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2) back-to-back -> one bubble cycle, add emitted one cycle later, stall_count=1.
REQ-031 0xFFFFFFFF -> out_ctrl.illegal=1, reg_write=0, halted=1, in_ready=0 for 5 cycles; flush -> RUN, next instruction accepted.
REQ-032 RV32E=1 with 0x00100813 (addi x16,x0,1) -> illegal=1; with RV32E=0 the same word is legal.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; flush together with in_valid -> out_valid=0 next cycle and the instruction is not emitted.
REQ-034 Reset asserted while out_valid=1 -> out_valid=0 immediately; stall_count=0.
